// File: rtl/jedec_p.sv
// Shared eMMC definitions: data width, host request record and host front-end FSM states.
package jedec_p;

  localparam int DAT_WIDTH = 8;

  typedef struct packed {
    logic                 we;
    logic [DAT_WIDTH-1:0] dat;
  } emmc_req_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_LO, WAIT_HI} host_if_state_t;

endpackage

// File: rtl/emmc_sync_fifo.sv
// Single-clock FIFO with an extra pointer bit so full and empty stay distinct at wrap-around.
module emmc_sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] dat_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr == rd_ptr);
  assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset; the pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= dat_i;
  end

endmodule

// File: rtl/emmc_host_if.sv
// Host request front-end for emmc_sm: queues byte requests, issues them one at a time,
// collects read bytes into a response FIFO and watches for a stalled emmc_sm.
module emmc_host_if
  import jedec_p::*;
#(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic                 clk_i,
  input  logic                 arst_n_i,
  input  logic                 req_valid_i,
  input  logic                 req_we_i,
  input  logic [DAT_WIDTH-1:0] req_dat_i,
  output logic                 req_ready_o,
  output logic                 rsp_valid_o,
  output logic [DAT_WIDTH-1:0] rsp_dat_o,
  input  logic                 rsp_ready_i,
  output logic                 sm_start_o,
  output logic                 sm_we_o,
  output logic [DAT_WIDTH-1:0] sm_dat_o,
  input  logic [DAT_WIDTH-1:0] sm_dat_i,
  input  logic                 sm_dvalid_i,
  input  logic                 sm_ready_i,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0] WD_ONE  = {{(WD_W-1){1'b0}}, 1'b1};

  host_if_state_t state_q, state_d;

  emmc_req_t            req_in;
  emmc_req_t            req_head;
  logic                 req_full;
  logic                 req_empty;
  logic                 req_pop;
  logic                 rsp_full;
  logic                 rsp_empty;
  logic                 rsp_push;
  logic                 waiting;
  logic                 timeout;
  logic [WD_W-1:0]      wd_q;
  logic                 cur_we_q;
  logic                 got_rd_q;
  logic                 start_q;
  logic                 we_q;
  logic [DAT_WIDTH-1:0] dat_q;
  logic                 busy_q;
  logic                 err_q;

  assign req_in      = '{we: req_we_i, dat: req_dat_i};
  assign req_ready_o = !req_full;
  assign rsp_valid_o = !rsp_empty;

  emmc_sync_fifo #(
    .WIDTH ($bits(emmc_req_t)),
    .DEPTH (DEPTH)
  ) u_req_fifo (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .push_i   (req_valid_i),
    .dat_i    (req_in),
    .pop_i    (req_pop),
    .full_o   (req_full),
    .empty_o  (req_empty),
    .head_o   (req_head)
  );

  emmc_sync_fifo #(
    .WIDTH (DAT_WIDTH),
    .DEPTH (DEPTH)
  ) u_rsp_fifo (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .push_i   (rsp_push),
    .dat_i    (sm_dat_i),
    .pop_i    (rsp_ready_i),
    .full_o   (rsp_full),
    .empty_o  (rsp_empty),
    .head_o   (rsp_dat_o)
  );

  assign waiting = (state_q == WAIT_LO) || (state_q == WAIT_HI);
  assign req_pop = (state_q == ISSUE);

  // Only the first dvalid of a read is kept; an operation abandoned by the watchdog pushes nothing.
  assign rsp_push = waiting && sm_dvalid_i && !cur_we_q && !got_rd_q && !timeout;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // A read is only issued when its byte is guaranteed a slot in the response FIFO.
  always_comb begin
    state_d = state_q;
    timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (!req_empty && sm_ready_i && (req_head.we || !rsp_full)) state_d = ISSUE;
      end
      ISSUE: state_d = WAIT_LO;
      WAIT_LO: begin
        if (!sm_ready_i) begin
          state_d = WAIT_HI;
        end else if (wd_q == WD_LAST) begin
          timeout = 1'b1;
          state_d = IDLE;
        end
      end
      WAIT_HI: begin
        if (sm_ready_i) begin
          state_d = IDLE;
        end else if (wd_q == WD_LAST) begin
          timeout = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      wd_q     <= '0;
      cur_we_q <= 1'b0;
      got_rd_q <= 1'b0;
      start_q  <= 1'b0;
      we_q     <= 1'b0;
      dat_q    <= '0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (state_d != state_q || !waiting) wd_q <= '0;
      else                                wd_q <= wd_q + WD_ONE;

      if (state_q == ISSUE) begin
        cur_we_q <= req_head.we;
        got_rd_q <= 1'b0;
      end else if (rsp_push) begin
        got_rd_q <= 1'b1;
      end

      // Command outputs are loaded on the IDLE decision so they are stable throughout ISSUE.
      start_q <= (state_d == ISSUE);
      if (state_q == IDLE && state_d == ISSUE) begin
        we_q  <= req_head.we;
        dat_q <= req_head.dat;
      end

      busy_q <= (state_d != IDLE);
      if (timeout) err_q <= 1'b1;
    end
  end

  assign sm_start_o = start_q;
  assign sm_we_o    = we_q;
  assign sm_dat_o   = dat_q;
  assign busy_o     = busy_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_emmc_host_if.sv
// Scoreboard bench for emmc_host_if with a cycle-level emmc_sm model (normal, hold, stuck, double-dvalid).
module tb_emmc_host_if;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_we = 1'b0;
  logic [7:0] req_dat = 8'h00;
  logic       rsp_ready = 1'b0;
  logic [7:0] sm_dat = 8'h00;
  logic       sm_dvalid = 1'b0;
  logic       sm_ready = 1'b1;

  logic       req_ready_o;
  logic       rsp_valid_o;
  logic [7:0] rsp_dat_o;
  logic       sm_start_o;
  logic       sm_we_o;
  logic [7:0] sm_dat_o;
  logic       busy_o;
  logic       err_o;

  int tests_run = 0;
  int tests_failed = 0;

  logic [8:0] exp_op[$];
  logic [7:0] exp_rsp[$];
  logic [7:0] rd_q[$];

  int   n_started = 0;
  int   overlap = 0;
  int   model_cnt = 0;
  logic model_we = 1'b0;
  logic model_hold = 1'b0;
  logic model_stuck = 1'b0;
  logic model_dup = 1'b0;

  emmc_host_if #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk_i       (clk),
    .arst_n_i    (arst_n),
    .req_valid_i (req_valid),
    .req_we_i    (req_we),
    .req_dat_i   (req_dat),
    .req_ready_o (req_ready_o),
    .rsp_valid_o (rsp_valid_o),
    .rsp_dat_o   (rsp_dat_o),
    .rsp_ready_i (rsp_ready),
    .sm_start_o  (sm_start_o),
    .sm_we_o     (sm_we_o),
    .sm_dat_o    (sm_dat_o),
    .sm_dat_i    (sm_dat),
    .sm_dvalid_i (sm_dvalid),
    .sm_ready_i  (sm_ready),
    .busy_o      (busy_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Queue one host request once the request FIFO has room and record what must come out of it.
  task automatic applyStimulus(input logic we, input logic [7:0] dat, input logic [7:0] rdat);
    int guard = 0;
    while (!req_ready_o && guard < 500) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!req_ready_o) begin
      checkOutput("req_ready_wait", 32'(req_ready_o), 32'd1);
    end else begin
      req_valid = 1'b1;
      req_we    = we;
      req_dat   = dat;
      exp_op.push_back({we, dat});
      if (!we) begin
        rd_q.push_back(rdat);
        exp_rsp.push_back(rdat);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
    end
  endtask

  task automatic waitDrain(input int max_cycles);
    int i = 0;
    while ((exp_op.size() != 0 || exp_rsp.size() != 0 || busy_o || model_cnt != 0) && i < max_cycles) begin
      @(posedge clk); #1;
      i++;
    end
    if (i >= max_cycles)
      checkOutput("drain_timeout", 32'(exp_op.size() + exp_rsp.size() + model_cnt) + 32'(busy_o), 32'd0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_start"},     32'(sm_start_o),  32'd0);
    checkOutput({tag, "_we"},        32'(sm_we_o),     32'd0);
    checkOutput({tag, "_dat"},       32'(sm_dat_o),    32'd0);
    checkOutput({tag, "_busy"},      32'(busy_o),      32'd0);
    checkOutput({tag, "_err"},       32'(err_o),       32'd0);
    checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid_o), 32'd0);
    checkOutput({tag, "_req_ready"}, 32'(req_ready_o), 32'd1);
  endtask

  // emmc_sm model: accepts start while ready, drops ready for four cycles, returns a byte mid-way.
  initial begin
    logic [8:0] op;
    forever begin
      @(negedge clk);
      sm_dvalid = 1'b0;
      if (!arst_n) begin
        model_cnt = 0;
        sm_ready  = 1'b1;
      end else if (model_cnt > 0) begin
        if (sm_start_o) overlap++;
        model_cnt--;
        if (model_cnt == 2 || (model_cnt == 1 && model_dup)) begin
          if (model_cnt == 2 && !model_we) sm_dat = (rd_q.size() > 0) ? rd_q.pop_front() : 8'h00;
          else                             sm_dat = 8'hEE;
          if (!model_we || model_dup) sm_dvalid = 1'b1;
        end
        if (model_cnt == 0) sm_ready = !model_hold;
      end else if (sm_start_o && sm_ready) begin
        n_started++;
        if (exp_op.size() == 0) begin
          checkOutput("op_extra", 32'(sm_start_o), 32'd0);
        end else begin
          op = exp_op.pop_front();
          checkOutput("op_we", 32'(sm_we_o), 32'(op[8]));
          if (op[8]) checkOutput("op_dat", 32'(sm_dat_o), 32'(op[7:0]));
        end
        if (!model_stuck) begin
          model_we  = sm_we_o;
          model_cnt = 4;
          sm_ready  = 1'b0;
        end
      end else begin
        sm_ready = !model_hold;
      end
    end
  end

  // Response monitor: every byte the host pops must be the next expected read byte.
  initial begin
    logic [7:0] want;
    forever begin
      @(negedge clk);
      if (arst_n && rsp_valid_o && rsp_ready) begin
        if (exp_rsp.size() == 0) begin
          checkOutput("rsp_extra", 32'(rsp_valid_o), 32'd0);
        end else begin
          want = exp_rsp.pop_front();
          checkOutput("rsp_dat", 32'(rsp_dat_o), 32'(want));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] aborted");
  end

  initial begin
    int base;
    int guard;

    // Power-on reset values
    repeat (3) @(negedge clk);
    #1;
    checkResetValues("por");
    @(posedge clk); #1;
    arst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Single write with start latency, dvalid during a write must be ignored
    model_dup = 1'b1;
    base = n_started;
    applyStimulus(1'b1, 8'h55, 8'h00);
    checkOutput("wr_start_early", 32'(sm_start_o), 32'd0);
    @(posedge clk); #1;
    checkOutput("wr_start", 32'(sm_start_o), 32'd1);
    checkOutput("wr_we",    32'(sm_we_o),    32'd1);
    checkOutput("wr_dat",   32'(sm_dat_o),   32'h55);
    waitDrain(100);
    repeat (2) @(posedge clk); #1;
    checkOutput("wr_busy_low", 32'(busy_o), 32'd0);
    checkOutput("wr_no_rsp", 32'(rsp_valid_o), 32'd0);
    checkOutput("wr_count", 32'(n_started - base), 32'd1);

    // Single read, response one cycle after dvalid, second dvalid ignored
    applyStimulus(1'b0, 8'h00, 8'hA3);
    guard = 0;
    do begin
      @(negedge clk); #1;
      guard++;
    end while (!sm_dvalid && guard < 50);
    checkOutput("rd_dvalid_seen", 32'(sm_dvalid), 32'd1);
    checkOutput("rd_rsp_not_yet", 32'(rsp_valid_o), 32'd0);
    @(negedge clk); #1;
    checkOutput("rd_rsp_valid", 32'(rsp_valid_o), 32'd1);
    checkOutput("rd_rsp_dat",   32'(rsp_dat_o),   32'hA3);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    waitDrain(100);
    repeat (3) @(posedge clk); #1;
    checkOutput("rd_rsp_empty", 32'(rsp_valid_o), 32'd0);
    model_dup = 1'b0;

    // Interleaved writes and reads
    base = n_started;
    applyStimulus(1'b1, 8'h01, 8'h00);
    applyStimulus(1'b0, 8'h00, 8'h11);
    applyStimulus(1'b1, 8'hFE, 8'h00);
    applyStimulus(1'b0, 8'h00, 8'h22);
    waitDrain(300);
    checkOutput("il_count", 32'(n_started - base), 32'd4);
    rsp_ready = 1'b0;

    // Back-pressure: ready held low blocks issue, request FIFO fills, response FIFO caps reads in flight
    model_hold = 1'b1;
    repeat (3) @(posedge clk); #1;
    base = n_started;
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 8'h00, 8'(8'h40 + i));
    checkOutput("bp_req_full", 32'(req_ready_o), 32'd0);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_dat   = 8'hEE;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk); #1;
    checkOutput("bp_ready_blocks", 32'(n_started - base), 32'd0);
    model_hold = 1'b0;
    applyStimulus(1'b0, 8'h00, 8'h48);
    applyStimulus(1'b0, 8'h00, 8'h49);
    repeat (150) @(posedge clk); #1;
    checkOutput("bp_issued", 32'(n_started - base), 32'd8);
    checkOutput("bp_rsp_valid", 32'(rsp_valid_o), 32'd1);
    checkOutput("bp_req_room", 32'(req_ready_o), 32'd1);
    rsp_ready = 1'b1;
    waitDrain(400);
    checkOutput("bp_all_done", 32'(n_started - base), 32'd10);

    // Watchdog: model accepts start but never drops ready
    checkOutput("to_err_before", 32'(err_o), 32'd0);
    model_stuck = 1'b1;
    applyStimulus(1'b1, 8'h77, 8'h00);
    guard = 0;
    do begin
      @(negedge clk); #1;
      guard++;
    end while (!sm_start_o && guard < 20);
    checkOutput("to_start_seen", 32'(sm_start_o), 32'd1);
    repeat (16) @(negedge clk);
    #1;
    checkOutput("to_err_early", 32'(err_o), 32'd0);
    checkOutput("to_busy_wait", 32'(busy_o), 32'd1);
    @(negedge clk); #1;
    checkOutput("to_err_set",  32'(err_o),  32'd1);
    checkOutput("to_busy_low", 32'(busy_o), 32'd0);
    model_stuck = 1'b0;
    base = n_started;
    applyStimulus(1'b1, 8'h88, 8'h00);
    waitDrain(100);
    checkOutput("to_next_issued", 32'(n_started - base), 32'd1);
    checkOutput("to_err_sticky", 32'(err_o), 32'd1);

    // Reset in the middle of a write with a read still queued
    rsp_ready = 1'b0;
    applyStimulus(1'b1, 8'h5A, 8'h00);
    applyStimulus(1'b0, 8'h00, 8'hC3);
    guard = 0;
    while (model_cnt == 0 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("rst_mid_op", 32'(model_cnt != 0), 32'd1);
    arst_n = 1'b0;
    exp_op.delete();
    exp_rsp.delete();
    rd_q.delete();
    @(negedge clk); #1;
    checkResetValues("rst");
    repeat (2) @(posedge clk); #1;
    arst_n = 1'b1;
    base = n_started;
    repeat (20) @(posedge clk); #1;
    checkOutput("rst_no_start", 32'(n_started - base), 32'd0);
    checkOutput("rst_rsp_empty", 32'(rsp_valid_o), 32'd0);
    checkOutput("rst_busy", 32'(busy_o), 32'd0);

    checkOutput("no_overlap", 32'(overlap), 32'd0);
    checkOutput("ops_left", 32'(exp_op.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/emmc_host_if.md
# emmc_host_if

Request front-end that sits directly upstream of `emmc_sm`. It buffers host byte-write and byte-read requests in a request FIFO and issues them one at a time over the `emmc_sm` start/ready handshake. Read bytes returned on `dvalid` go into a response FIFO. A watchdog flags an `emmc_sm` that stops answering.

## Interface
- `DEPTH`, 8: entries in each FIFO; power of two, ≥2.
- `TIMEOUT`, 4096: maximum cycles to wait on each `sm_ready_i` edge.
- `clk_i` in 1: core clock, same clock as `emmc_sm`.
- `arst_n_i` in 1: asynchronous, active-low reset.
- `req_valid_i` in 1: host request valid.
- `req_we_i` in 1: 1 = write byte, 0 = read byte.
- `req_dat_i` in `jedec_p::DAT_WIDTH`: write byte; ignored for reads.
- `req_ready_o` out 1: request FIFO not full.
- `rsp_valid_o` out 1: response FIFO not empty.
- `rsp_dat_o` out `jedec_p::DAT_WIDTH`: head of the response FIFO.
- `rsp_ready_i` in 1: host pops the response.
- `sm_start_o` out 1: drives `emmc_sm.start_i`.
- `sm_we_o` out 1: drives `emmc_sm.we_i`.
- `sm_dat_o` out `DAT_WIDTH`: drives `emmc_sm.dat_i`.
- `sm_dat_i` in `DAT_WIDTH`: from `emmc_sm.dat_o`.
- `sm_dvalid_i` in 1: from `emmc_sm.dvalid_o`.
- `sm_ready_i` in 1: from `emmc_sm.ready_o`.
- `busy_o` out 1: the FSM is not in IDLE.
- `err_o` out 1: sticky timeout flag.

## Operation
**`emmc_sm` contract.** `emmc_sm` samples `start`/`we`/`dat` on a clock edge where `ready` is high. It then drops `ready`, pulses `dvalid` once during a read, and raises `ready` again when the operation is done.

**Request push.** A request is pushed when `req_valid_i && req_ready_o`.

**FSM states: IDLE, ISSUE, WAIT_LO, WAIT_HI.**
- **IDLE → ISSUE** when all of these hold:
  - the request FIFO is not empty;
  - `sm_ready_i` = 1;
  - the head is a write, or the response FIFO has at least one free slot once in-flight reads are counted. Since only one operation is ever in flight, this means "not full".
- **ISSUE** (exactly 1 cycle):
  - `sm_start_o` = 1, with `sm_we_o`/`sm_dat_o` taken from the FIFO head.
  - The head is popped and its `we` is latched into `cur_we`.
  - Next state is WAIT_LO.
- **WAIT_LO**: wait for `sm_ready_i` = 0, then go to WAIT_HI.
- **WAIT_HI**: wait for `sm_ready_i` = 1, then go to IDLE.
- **Read capture.** In WAIT_LO or WAIT_HI, `sm_dvalid_i` with `cur_we` = 0 pushes `sm_dat_i` into the response FIFO.
  - A second `dvalid` in the same operation is ignored.
  - `dvalid` during a write is ignored.
- **Watchdog.** In WAIT_LO and WAIT_HI, a counter that is cleared on every state entry counts cycles.
  - On reaching `TIMEOUT`: set `err_o`, return to IDLE, and push nothing.
  - `err_o` clears only on reset.
  - Issuing continues after an error.
- **Outputs outside ISSUE.** `sm_start_o` = 0. `sm_we_o` and `sm_dat_o` hold their last values.

## Timing
**Reset values.**
- FSM = IDLE.
- Both FIFOs empty.
- `sm_start_o` = 0, `sm_we_o` = 0, `sm_dat_o` = 0.
- `err_o` = 0, `busy_o` = 0.
- `rsp_valid_o` = 0, `req_ready_o` = 1.

**Latency.**
- Request push to `sm_start_o`: 2 cycles minimum (FIFO write, IDLE decision, ISSUE).
- `sm_dvalid_i` to `rsp_valid_o`: 1 cycle.

**FIFO rules.**
- Full: `req_ready_o` = 0; pushes are ignored.
- Empty: `rsp_valid_o` = 0; pops are ignored.
- Simultaneous push and pop on the same FIFO: both happen and the level is unchanged.
- Pointers are `$clog2(DEPTH)+1` bits wide, so full and empty can be told apart at wrap-around.

**Other boundaries.**
- A request arriving while the FSM is busy is queued.
- `sm_ready_i` low in IDLE blocks issue.
- Reset asserted mid-operation aborts immediately and flushes both FIFOs. A byte that is in flight is lost.

**Registering.** All outputs are registered except `req_ready_o`, `rsp_valid_o` and `rsp_dat_o`, which decode FIFO state or read its head directly.

## Structure
- **Shared package.** Add to `jedec_p`:
  - `typedef struct packed {logic we; logic [DAT_WIDTH-1:0] dat;} emmc_req_t`;
  - `typedef enum logic [1:0] {IDLE, ISSUE, WAIT_LO, WAIT_HI} host_if_state_t`.
- **Sub-module.** One sub-module, `emmc_sync_fifo` (parameters `WIDTH`, `DEPTH`; `clk_i`/`arst_n_i`; push/pop/full/empty/head). It is instantiated twice: request width `DAT_WIDTH+1`, response width `DAT_WIDTH`.

## Test plan
- **Reset:** hold `arst_n_i` = 0 mid-write → all outputs at their reset values, both FIFOs empty, no `sm_start_o` after release.
- **Write:** push write 0x55 → one `sm_start_o` pulse with `sm_we_o` = 1 and `sm_dat_o` = 0x55; `busy_o` falls after the model raises ready.
- **Read:** push a read; model returns 0xA3 on `dvalid` → `rsp_valid_o` = 1 with `rsp_dat_o` = 0xA3 one cycle later; pop → `rsp_valid_o` = 0.
- **Back-pressure:** `rsp_ready_i` = 0, push 10 reads with `DEPTH` = 8 → exactly 8 operations issued, `req_ready_o` low while the request FIFO is full; release → all 10 complete in order.
- **Interleave:** W 0x01, R, W 0xFE, R with the model returning 0x11 then 0x22 → `sm_start_o` sequence matches, responses 0x11 then 0x22, never two operations in flight.
- **Timeout:** model keeps ready high after start with `TIMEOUT` = 16 → `err_o` = 1 after 16 cycles in WAIT_LO, FSM back in IDLE, next queued request still issues.
